// File: rtl/bram_log_arbiter_pkg.sv
// bram_log_arbiter_pkg: state encodings, grant constants and defaults for the logging BRAM arbiter
package bram_log_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/bram_arb_watchdog.sv
// bram_arb_watchdog: stalled-strobe counter that fires a one-cycle abort and a sticky flag
module bram_arb_watchdog
  import bram_log_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic wb_clk_i,
  input  logic reset_n,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic fire,
  output logic flag
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign fire = active & (cnt == CW'(TIMEOUT));
  always_ff @(posedge wb_clk_i)
    if (!reset_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      cnt  <= (!active || ack) ? '0 : (stb && cnt != CW'(TIMEOUT)) ? cnt + 1'b1 : cnt;
      flag <= flag | fire;
    end
endmodule

// File: rtl/bram_log_arbiter.sv
// bram_log_arbiter: two-master round-robin Wishbone arbiter for the shared logging BRAM
// Optional watchdog enabled by defining BRAM_ARB_TIMEOUT_EN.
module bram_log_arbiter
  import bram_log_arbiter_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o,
  output logic             timeout_flag_o
);
  state_t state, state_nxt;
  logic last_m1, last_m1_nxt;
  logic g0, g1, c0, c1, abort;
  logic [1:0] lock;
  always_ff @(posedge wb_clk_i)
    if (!reset_n) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_m1 <= last_m1_nxt;
    end
  // a master aborted by the watchdog is ignored until it lets go of cyc
  assign c0 = m0_cyc_i & ~lock[0];
  assign c1 = m1_cyc_i & ~lock[1];
  always_comb begin
    state_nxt   = state;
    last_m1_nxt = last_m1;
    case (state)
      IDLE: state_nxt = (c0 && c1) ? (last_m1 ? GNT0 : GNT1) : c0 ? GNT0 : c1 ? GNT1 : IDLE;
      GNT0:
        if (!m0_cyc_i || abort) begin
          state_nxt   = IDLE;
          last_m1_nxt = 1'b0;
        end
      GNT1:
        if (!m1_cyc_i || abort) begin
          state_nxt   = IDLE;
          last_m1_nxt = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt_o = g0 ? GNT_M0 : g1 ? GNT_M1 : GNT_NONE;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = g0 ? m0_cyc_i & m0_stb_i : g1 ? m1_cyc_i & m1_stb_i : 1'b0;
  assign s_we_o  = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'h0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
`ifdef BRAM_ARB_TIMEOUT_EN
  bram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .wb_clk_i(wb_clk_i),
    .reset_n (reset_n),
    .active  (g0 | g1),
    .stb     (s_stb_o),
    .ack     (s_ack_i),
    .fire    (abort),
    .flag    (timeout_flag_o)
  );
  always_ff @(posedge wb_clk_i)
    if (!reset_n) lock <= 2'b00;
    else lock <= {(abort & g1) | (lock[1] & m1_cyc_i), (abort & g0) | (lock[0] & m0_cyc_i)};
  assign m0_err_o = abort & g0;
  assign m1_err_o = abort & g1;
`else
  assign abort = 1'b0;
  assign lock = 2'b00;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif
endmodule

// File: tb/tb_bram_log_arbiter.sv
// tb_bram_log_arbiter: directed checks of grant sequencing, bus mux, ack routing and watchdog
module tb_bram_log_arbiter;
  logic wb_clk_i = 1'b0, reset_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0, m1_adr = 0, m1_dat = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_flag_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_dat_i = 0;
  logic s_ack_i = 0;
  logic [1:0] gnt_o;
  int checks = 0, errors = 0;
  always #5 wb_clk_i = ~wb_clk_i;
  bram_log_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .timeout_flag_o(timeout_flag_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask
  initial begin
    bit own;
    m0_cyc = 1; m1_cyc = 1;
    tick(); tick();
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_sstb", s_stb_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    check("rst_errs", {m0_err_o, m1_err_o}, 0);
    check("rst_flag", timeout_flag_o, 0);
    reset_n = 1;
    tick();
    check("rel_gnt", gnt_o, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    check("rel_idle", gnt_o, 2'b00);
    // single m0 write
    m1_adr = 32'h20; m1_dat = 32'h12345678; m1_sel = 4'b0011; m1_we = 0;
    m0_adr = 32'h10; m0_dat = 32'hABCDEF01; m0_sel = 4'hF; m0_we = 1;
    m0_cyc = 1; m0_stb = 1; #1;
    check("wr_idle_scyc", s_cyc_o, 0);
    check("wr_idle_sadr", s_adr_o, 0);
    tick();
    check("wr_gnt", gnt_o, 2'b01);
    check("wr_scyc", s_cyc_o, 1);
    check("wr_sstb", s_stb_o, 1);
    check("wr_swe", s_we_o, 1);
    check("wr_ssel", s_sel_o, 4'hF);
    check("wr_sadr", s_adr_o, 32'h10);
    check("wr_sdat", s_dat_o, 32'hABCDEF01);
    tick(); tick();
    s_ack_i = 1; s_dat_i = 32'hCAFEF00D; #1;
    check("wr_m0ack", m0_ack_o, 1);
    check("wr_m1ack", m1_ack_o, 0);
    check("wr_m0dat", m0_dat_o, 32'hCAFEF00D);
    check("wr_m1dat", m1_dat_o, 32'hCAFEF00D);
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0; #1;
    check("wr_ack_drop", m0_ack_o, 0);
    tick();
    check("wr_done", gnt_o, 2'b00);
    // contention: last owner m0, so m1 goes first
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      own = (k % 2 == 0);
      check("ct_gnt", gnt_o, own ? 2'b10 : 2'b01);
      check("ct_sadr", s_adr_o, own ? 32'h20 : 32'h10);
      check("ct_ssel", s_sel_o, own ? 4'b0011 : 4'hF);
      check("ct_swe", s_we_o, own ? 0 : 1);
      s_ack_i = 1; #1;
      check("ct_ack_own", own ? m1_ack_o : m0_ack_o, 1);
      check("ct_ack_other", own ? m0_ack_o : m1_ack_o, 0);
      s_ack_i = 0;
      if (own) m1_cyc = 0; else m0_cyc = 0;
      #1;
      check("ct_hold", gnt_o, own ? 2'b10 : 2'b01);
      check("ct_scyc_low", s_cyc_o, 0);
      tick();
      s_ack_i = 1;
      if (own) m1_cyc = 1; else m0_cyc = 1;
      #1;
      check("ct_idle", gnt_o, 2'b00);
      check("ct_idle_acks", {m0_ack_o, m1_ack_o}, 0);
      check("ct_idle_scyc", s_cyc_o, 0);
      s_ack_i = 0;
      tick();
    end
    // abandon: m1 owns, drops cyc before ack
    check("ab_gnt", gnt_o, 2'b10);
    m0_cyc = 0; m1_cyc = 0; #1;
    check("ab_scyc", s_cyc_o, 0);
    tick();
    s_ack_i = 1; #1;
    check("ab_idle", gnt_o, 2'b00);
    check("ab_late_ack", {m0_ack_o, m1_ack_o}, 0);
    s_ack_i = 0;
    // make m0 last owner, then reset during a new m0 grant
    m0_cyc = 1; tick();
    m0_cyc = 0; tick();
    m0_cyc = 1; m0_stb = 1; tick();
    check("mr_gnt", gnt_o, 2'b01);
    reset_n = 0; tick();
    s_ack_i = 1; #1;
    check("mr_gnt_clr", gnt_o, 2'b00);
    check("mr_scyc", s_cyc_o, 0);
    check("mr_ack_drop", m0_ack_o, 0);
    s_ack_i = 0; reset_n = 1; m1_cyc = 1;
    tick();
    check("mr_last_m1", gnt_o, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();
`ifdef BRAM_ARB_TIMEOUT_EN
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_no_err", m0_err_o, 0);
      tick();
    end
    check("to_err", m0_err_o, 1);
    check("to_m1err", m1_err_o, 0);
    check("to_gnt_hold", gnt_o, 2'b01);
    check("to_flag_pre", timeout_flag_o, 0);
    tick();
    check("to_err_pulse", m0_err_o, 0);
    check("to_flag", timeout_flag_o, 1);
    check("to_idle", gnt_o, 2'b00);
    tick(); tick();
    check("to_locked", gnt_o, 2'b00);
    m0_cyc = 0; tick();
    m1_cyc = 1; m1_stb = 1; tick();
    check("to_m1_gnt", gnt_o, 2'b10);
    check("to_flag_sticky", timeout_flag_o, 1);
`else
    m0_cyc = 1; m0_stb = 1;
    tick();
    repeat (20) tick();
    check("nt_gnt", gnt_o, 2'b01);
    check("nt_err", m0_err_o, 0);
    check("nt_flag", timeout_flag_o, 0);
`endif
    m0_cyc = 0; m1_cyc = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
